// File: rtl/core_pmp_pkg.sv
// Shared PMP definitions: CSR bases, pmpcfg field encodings and the loader state enum.
`timescale 1ns/1ps
package core_pmp_pkg;

  localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
  localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

  localparam logic [1:0] A_OFF   = 2'd0;
  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  localparam int CFG_L    = 7;
  localparam int CFG_A_HI = 4;
  localparam int CFG_A_LO = 3;
  localparam int CFG_X    = 2;
  localparam int CFG_W    = 1;
  localparam int CFG_R    = 0;

  typedef enum logic [2:0] {
    LD_IDLE, LD_WADDR, LD_CLRCFG, LD_SETCFG, LD_VADDR, LD_VCFG, LD_FIN
  } ld_state_e;

  // RV64 packs eight cfg bytes per even-numbered pmpcfg CSR.
  function automatic logic [11:0] cfg_csr(input logic [3:0] idx);
    return PMPCFG_BASE + 12'({idx[3], 1'b0});
  endfunction

endpackage

// File: rtl/core_pmp_loader_if.sv
// CSR access bus borrowed from the CSR unit via request/grant.
`timescale 1ns/1ps
interface core_pmp_loader_if;
  logic        bus_req;
  logic        bus_gnt;
  logic        csr_en;
  logic        csr_wr;
  logic        csr_wr_set;
  logic        csr_wr_clr;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata;
  logic [63:0] csr_rdata;
  logic        csr_error;

  modport master (
    output bus_req, csr_en, csr_wr, csr_wr_set, csr_wr_clr, csr_addr, csr_wdata,
    input  bus_gnt, csr_rdata, csr_error
  );
  modport slave (
    input  bus_req, csr_en, csr_wr, csr_wr_set, csr_wr_clr, csr_addr, csr_wdata,
    output bus_gnt, csr_rdata, csr_error
  );
endinterface

// File: rtl/core_pmp_loader.sv
// Boot-time PMP sequencer: per region writes pmpaddr, clears+sets the cfg byte,
// then reads both back; first readback mismatch aborts the run with err.
`timescale 1ns/1ps
module core_pmp_loader
  import core_pmp_pkg::*;
#(
  parameter int ADDR_WIDTH  = 56,
  parameter int NUM_REGIONS = 8
) (
  input  logic                  g_clk,
  input  logic                  g_resetn,
  input  logic                  start,
  input  logic [4:0]            num_regions,
  output logic [3:0]            tbl_idx,
  input  logic [ADDR_WIDTH-1:0] tbl_addr,
  input  logic [7:0]            tbl_cfg,
  core_pmp_loader_if.master     bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            err_region
);

  ld_state_e   state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [3:0]  err_region_q, err_region_d;

  logic [4:0]  cnt_clamped;
  logic [63:0] addr_ext;
  logic [5:0]  sh;
  logic [11:0] addr_csr, cfg_addr;
  logic [7:0]  rd_byte;
  logic        gnt;
  logic        unused_csr_error;

  assign unused_csr_error = bus.csr_error;
  assign gnt         = bus.bus_gnt;
  assign cnt_clamped = (num_regions > 5'(NUM_REGIONS)) ? 5'(NUM_REGIONS) : num_regions;
  assign addr_ext    = 64'(tbl_addr);
  assign sh          = {idx_q[2:0], 3'b000};
  assign addr_csr    = PMPADDR_BASE + 12'(idx_q);
  assign cfg_addr    = cfg_csr(idx_q);
  assign rd_byte     = 8'(bus.csr_rdata >> sh);

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q      <= LD_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      err_region_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      err_region_q <= err_region_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    err_d          = err_q;
    err_region_d   = err_region_q;
    bus.bus_req    = 1'b0;
    bus.csr_en     = 1'b0;
    bus.csr_wr     = 1'b0;
    bus.csr_wr_set = 1'b0;
    bus.csr_wr_clr = 1'b0;
    bus.csr_addr   = '0;
    bus.csr_wdata  = '0;
    done           = 1'b0;
    // Every bus state stalls in place until granted.
    if (state_q != LD_IDLE && state_q != LD_FIN) begin
      bus.bus_req = 1'b1;
      bus.csr_en  = gnt;
    end
    case (state_q)
      LD_IDLE: if (start) begin
        err_d        = 1'b0;
        err_region_d = '0;
        idx_d        = '0;
        cnt_d        = cnt_clamped;
        state_d      = (cnt_clamped == 5'd0) ? LD_FIN : LD_WADDR;
      end
      LD_WADDR: begin
        bus.csr_addr  = addr_csr;
        bus.csr_wdata = addr_ext;
        bus.csr_wr    = gnt;
        if (gnt) state_d = LD_CLRCFG;
      end
      LD_CLRCFG: begin
        bus.csr_addr   = cfg_addr;
        bus.csr_wdata  = 64'hFF << sh;
        bus.csr_wr_clr = gnt;
        if (gnt) state_d = LD_SETCFG;
      end
      LD_SETCFG: begin
        bus.csr_addr   = cfg_addr;
        bus.csr_wdata  = 64'(tbl_cfg) << sh;
        bus.csr_wr_set = gnt;
        if (gnt) state_d = LD_VADDR;
      end
      LD_VADDR: begin
        bus.csr_addr = addr_csr;
        if (gnt) begin
          if (bus.csr_rdata != addr_ext) begin
            err_d        = 1'b1;
            err_region_d = idx_q;
            state_d      = LD_FIN;
          end else begin
            state_d = LD_VCFG;
          end
        end
      end
      LD_VCFG: begin
        bus.csr_addr = cfg_addr;
        if (gnt) begin
          if (rd_byte != tbl_cfg) begin
            err_d        = 1'b1;
            err_region_d = idx_q;
            state_d      = LD_FIN;
          end else if (5'(idx_q) + 5'd1 < cnt_q) begin
            idx_d   = idx_q + 4'd1;
            state_d = LD_WADDR;
          end else begin
            state_d = LD_FIN;
          end
        end
      end
      LD_FIN: begin
        done    = 1'b1;
        state_d = LD_IDLE;
      end
      default: state_d = LD_IDLE;
    endcase
  end

  assign busy       = (state_q != LD_IDLE);
  assign tbl_idx    = idx_q;
  assign err        = err_q;
  assign err_region = err_region_q;

endmodule
